// File: rtl/rom_access_arbiter_pkg.sv
// Shared types and default geometry for the coefficient-ROM access arbiter.
package rom_arb_pkg;

   localparam int unsigned ADDR_W_DEF = 4;
   localparam int unsigned DATA_W_DEF = 10;
   localparam int unsigned DEPTH_DEF  = 10;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_RESP  = 2'd2
   } state_t;

endpackage

// File: rtl/rom_access_arbiter_rr_arb2.sv
// Two-way round-robin grant: a lone requester always wins, ties go to the
// requester that did not win last.
module rr_arb2 (
   input  logic [1:0] valid,
   input  logic       last_grant,
   output logic [1:0] grant
);

   always_comb begin
      grant = '0;
      case (valid)
         2'b01:   grant = 2'b01;
         2'b10:   grant = 2'b10;
         2'b11:   grant = last_grant ? 2'b01 : 2'b10;
         default: grant = '0;
      endcase
   end

endmodule

// File: rtl/rom_access_arbiter.sv
// Shares one asynchronous-read ROM between two requesters, one read in flight,
// with out-of-range addresses answered with an error without touching the ROM.
module rom_access_arbiter
   import rom_arb_pkg::*;
#(
   parameter int unsigned ADDR_W = ADDR_W_DEF,
   parameter int unsigned DATA_W = DATA_W_DEF,
   parameter int unsigned DEPTH  = DEPTH_DEF,
   parameter int unsigned RD_LAT = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0_valid,
   input  logic [ADDR_W-1:0] req0_addr,
   output logic              req0_ready,
   input  logic              req1_valid,
   input  logic [ADDR_W-1:0] req1_addr,
   output logic              req1_ready,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic              resp_id,
   output logic [DATA_W-1:0] resp_data,
   output logic              resp_err,
   output logic              rom_cs,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [DATA_W-1:0] rom_data
);

   localparam int unsigned       CNT_W   = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
   localparam logic [CNT_W-1:0]  CNT_LD  = CNT_W'(RD_LAT - 1);
   localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W + 1)'(DEPTH);

   state_t              state, state_d;
   logic                last_grant, last_grant_d;
   logic [CNT_W-1:0]    cnt, cnt_d;
   logic                rom_cs_d;
   logic [ADDR_W-1:0]   rom_addr_d;
   logic                resp_id_d;
   logic [DATA_W-1:0]   resp_data_d;
   logic                resp_err_d;

   logic [1:0]          grant;
   logic [ADDR_W-1:0]   sel_addr;
   logic                in_range;

   rr_arb2 u_arb (
      .valid      ({req1_valid, req0_valid}),
      .last_grant (last_grant),
      .grant      (grant)
   );

   assign req0_ready = (state == ST_IDLE) && grant[0];
   assign req1_ready = (state == ST_IDLE) && grant[1];
   assign resp_valid = (state == ST_RESP);
   assign sel_addr   = grant[1] ? req1_addr : req0_addr;
   assign in_range   = {1'b0, sel_addr} < DEPTH_L;

   always_comb begin
      state_d      = state;
      last_grant_d = last_grant;
      cnt_d        = cnt;
      rom_cs_d     = rom_cs;
      rom_addr_d   = rom_addr;
      resp_id_d    = resp_id;
      resp_data_d  = resp_data;
      resp_err_d   = resp_err;
      case (state)
         ST_IDLE: begin
            if (|grant) begin
               last_grant_d = grant[1];
               resp_id_d    = grant[1];
               if (in_range) begin
                  state_d    = ST_ISSUE;
                  rom_addr_d = sel_addr;
                  rom_cs_d   = 1'b1;
                  cnt_d      = CNT_LD;
               end else begin
                  state_d     = ST_RESP;
                  resp_err_d  = 1'b1;
                  resp_data_d = '0;
                  rom_cs_d    = 1'b0;
               end
            end
         end
         ST_ISSUE: begin
            if (cnt == '0) begin
               resp_data_d = rom_data;
               resp_err_d  = 1'b0;
               rom_cs_d    = 1'b0;
               state_d     = ST_RESP;
            end else begin
               cnt_d = cnt - 1'b1;
            end
         end
         ST_RESP: begin
            if (resp_ready)
               state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // last_grant resets to 1 so requester 0 wins the first tie.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ST_IDLE;
         last_grant <= 1'b1;
         cnt        <= '0;
         rom_cs     <= 1'b0;
         rom_addr   <= '0;
         resp_id    <= 1'b0;
         resp_data  <= '0;
         resp_err   <= 1'b0;
      end else begin
         state      <= state_d;
         last_grant <= last_grant_d;
         cnt        <= cnt_d;
         rom_cs     <= rom_cs_d;
         rom_addr   <= rom_addr_d;
         resp_id    <= resp_id_d;
         resp_data  <= resp_data_d;
         resp_err   <= resp_err_d;
      end
   end

endmodule

// File: tb/tb_rom_access_arbiter.sv
// Randomised scoreboard bench for rom_access_arbiter against a transaction-level
// model of the arbitration, latency and ROM contents.
module tb_rom_access_arbiter;

   localparam int RD_LAT = 1;
   localparam int DEPTH  = 10;

   logic       clk = 1'b0;
   logic       rst;
   logic       req0_valid, req1_valid;
   logic [3:0] req0_addr, req1_addr;
   logic       req0_ready, req1_ready;
   logic       resp_valid, resp_ready;
   logic       resp_id;
   logic [9:0] resp_data;
   logic       resp_err;
   logic       rom_cs;
   logic [3:0] rom_addr;
   logic [9:0] rom_data;

   logic [9:0] m [16];

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic       id;
      logic [9:0] data;
      logic       err;
   } resp_t;

   resp_t      q[$];
   bit         busy;
   bit         last;
   logic [3:0] cur_addr;
   bit         cur_err;
   int         cyc;
   int         hs_cyc;
   int         due;
   bit         hs0, hs1;

   bit         held;
   resp_t      held_r;

   rom_access_arbiter #(.ADDR_W(4), .DATA_W(10), .DEPTH(DEPTH), .RD_LAT(RD_LAT)) dut (
      .clk        (clk),
      .rst        (rst),
      .req0_valid (req0_valid),
      .req0_addr  (req0_addr),
      .req0_ready (req0_ready),
      .req1_valid (req1_valid),
      .req1_addr  (req1_addr),
      .req1_ready (req1_ready),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_id    (resp_id),
      .resp_data  (resp_data),
      .resp_err   (resp_err),
      .rom_cs     (rom_cs),
      .rom_addr   (rom_addr),
      .rom_data   (rom_data)
   );

   always #5 clk = ~clk;

   assign rom_data = m[rom_addr];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s at t=%0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // Reference model: one outstanding transaction, round-robin tie break.
   always @(negedge clk) begin
      int  w;
      bit  exp_cs;
      if (rst) begin
         busy <= 0;
         last  = 1'b1;
         busy  = 1'b0;
         hs0   = 1'b0;
         hs1   = 1'b0;
         q.delete();
         chk("rst_req0_ready", 32'(req0_ready), 0);
         chk("rst_req1_ready", 32'(req1_ready), 0);
         chk("rst_resp_valid", 32'(resp_valid), 0);
         chk("rst_rom_cs",     32'(rom_cs), 0);
      end else begin
         cyc++;
         w = -1;
         if (!busy) begin
            if (req0_valid && req1_valid) w = last ? 0 : 1;
            else if (req0_valid)          w = 0;
            else if (req1_valid)          w = 1;
         end
         chk("req0_ready", 32'(req0_ready), 32'(w == 0));
         chk("req1_ready", 32'(req1_ready), 32'(w == 1));
         exp_cs = busy && !cur_err && (cyc > hs_cyc) && (cyc < due);
         chk("rom_cs", 32'(rom_cs), 32'(exp_cs));
         if (exp_cs) chk("rom_addr", 32'(rom_addr), 32'(cur_addr));
         chk("resp_valid", 32'(resp_valid), 32'(busy && cyc >= due));
         hs0 = req0_valid && req0_ready;
         hs1 = req1_valid && req1_ready;
         if (busy && resp_valid && resp_ready) busy = 1'b0;
         if (w >= 0) begin
            resp_t r;
            busy     = 1'b1;
            last     = (w == 1);
            cur_addr = (w == 1) ? req1_addr : req0_addr;
            cur_err  = cur_addr >= DEPTH;
            hs_cyc   = cyc;
            due      = cyc + (cur_err ? 1 : RD_LAT + 1);
            r.id     = (w == 1);
            r.err    = cur_err;
            r.data   = cur_err ? 10'h000 : 10'h100 + 10'(cur_addr);
            q.push_back(r);
         end
      end
   end

   // Monitor: compares each accepted response and checks stall stability.
   always @(negedge clk) begin
      if (rst) begin
         held = 1'b0;
      end else if (resp_valid) begin
         if (held) begin
            chk("stall_id",   32'(resp_id),   32'(held_r.id));
            chk("stall_data", 32'(resp_data), 32'(held_r.data));
            chk("stall_err",  32'(resp_err),  32'(held_r.err));
         end
         if (resp_ready) begin
            if (q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL resp_unexpected: got id=%0d data=%0h required no response", resp_id, resp_data);
            end else begin
               resp_t e;
               e = q.pop_front();
               chk("resp_id",   32'(resp_id),   32'(e.id));
               chk("resp_data", 32'(resp_data), 32'(e.data));
               chk("resp_err",  32'(resp_err),  32'(e.err));
            end
            held = 1'b0;
         end else begin
            held        = 1'b1;
            held_r.id   = resp_id;
            held_r.data = resp_data;
            held_r.err  = resp_err;
         end
      end else begin
         held = 1'b0;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      if (hs0) req0_valid = 1'b0;
      if (hs1) req1_valid = 1'b0;
   endtask

   task automatic req(input int n, input logic [3:0] a);
      if (n == 0) begin req0_valid = 1'b1; req0_addr = a; end
      else        begin req1_valid = 1'b1; req1_addr = a; end
   endtask

   task automatic wait_idle(input string name);
      for (int i = 0; i < 80; i++) begin
         tick();
         if (!req0_valid && !req1_valid && !busy) return;
      end
      checks++;
      failures++;
      $display("FAIL %s_timeout: got busy after 80 cycles, required idle", name);
   endtask

   initial begin
      for (int i = 0; i < 16; i++) m[i] = 10'h100 + 10'(i);
      rst = 1'b1;
      req0_valid = 1'b0; req1_valid = 1'b0;
      req0_addr  = '0;   req1_addr  = '0;
      resp_ready = 1'b1;
      repeat (3) tick();
      rst = 1'b0;

      // Tie after reset goes to requester 0, then requester 1.
      req(0, 4'd2); req(1, 4'd7);
      wait_idle("tie");
      req(0, 4'd3);
      wait_idle("single");
      req(1, 4'd12);
      wait_idle("oor12");
      req(0, 4'd9);
      wait_idle("addr9");
      req(1, 4'd10);
      wait_idle("addr10");
      req(0, 4'd15);
      wait_idle("addr15");
      req(0, 4'd0);
      wait_idle("lone_a");
      req(0, 4'd1);
      wait_idle("lone_b");

      // Stall the consumer with both requesters pending.
      resp_ready = 1'b0;
      req(0, 4'd5); req(1, 4'd6);
      repeat (7) tick();
      resp_ready = 1'b1;
      wait_idle("stall");

      for (int i = 0; i < 800; i++) begin
         tick();
         if (!req0_valid && ($urandom % 3 == 0)) req(0, 4'($urandom_range(0, 15)));
         if (!req1_valid && ($urandom % 3 == 0)) req(1, 4'($urandom_range(0, 15)));
         resp_ready = ($urandom % 4) != 0;
      end
      resp_ready = 1'b1;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      wait_idle("drain");

      // Asynchronous reset while a read is in progress.
      req(0, 4'd4);
      begin
         bit seen = 1'b0;
         for (int i = 0; i < 6 && !seen; i++) begin
            tick();
            if (rom_cs) seen = 1'b1;
         end
         chk("issue_reached", 32'(seen), 1);
      end
      #2 rst = 1'b1;
      req0_valid = 1'b0;
      #1;
      chk("async_rom_cs",     32'(rom_cs), 0);
      chk("async_rom_addr",   32'(rom_addr), 0);
      chk("async_resp_valid", 32'(resp_valid), 0);
      chk("async_resp_data",  32'(resp_data), 0);
      chk("async_resp_err",   32'(resp_err), 0);
      chk("async_resp_id",    32'(resp_id), 0);
      repeat (2) tick();
      rst = 1'b0;
      tick();
      req(0, 4'd0);
      wait_idle("post_reset");
      repeat (3) tick();
      chk("queue_empty", 32'(q.size()), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
